rv32i_control_decoder: RTL and testbench
========================================

# rv32i_control_decoder

Main control decoder of the RV32I 5-stage pipelined CPU, located in the decode stage. It turns the one-hot instruction-class flags from the opcode decoder into the control bundle for execute, memory, write-back and PC-select. The bundle is registered, so it is carried into the ID/EX boundary with one-cycle latency. Invalid flag patterns decode to a harmless NOP bundle.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- r_type  input  1  R-type ALU instruction
- i_type_lw  input  1  load word
- i_type_addi  input  1  I-type ALU-immediate instruction (addi/slti/…/srai)
- i_type_jalr  input  1  jalr
- s_type  input  1  store word
- sb_type  input  1  conditional branch
- u_type_auipc  input  1  auipc
- u_type_lui  input  1  lui
- uj_type  input  1  jal
- write  output  1  register-file write enable
- store  output  1  data-memory write enable
- load  output  1  data-memory read / write-back source is memory
- branch  output  1  conditional branch; the taken decision is made downstream
- alu_operand_a_selector  output  2  00 rs1, 01 PC, 10 constant zero, 11 reserved
- alu_operand_b_selector  output  1  0 rs2, 1 immediate
- immediate_selector  output  2  00 I, 01 S, 10 B, 11 U/J (the immediate generator separates U from J using opcode bit 3)
- next_pc_selector  output  2  00 PC+4, 01 branch target, 10 jal target, 11 jalr target (ALU result with LSB cleared)
- alu_operations_selector  output  3  000 ADD, 001 R-type (funct3/funct7), 010 I-arith (funct3, plus funct7 for shifts), 011–111 reserved

## Operation
- Valid input: exactly one flag high. Zero or more than one flag high gives the NOP bundle: all outputs 0, which means PC+4, operand A rs1, operand B rs2, I immediate, ADD.
- Decode per class, fields in order write, store, load, branch, opA, opB, imm, npc, aluop:
  - r_type: 1,0,0,0, 00, 0, 00, 00, 001
  - i_type_lw: 1,0,1,0, 00, 1, 00, 00, 000
  - i_type_addi: 1,0,0,0, 00, 1, 00, 00, 010
  - i_type_jalr: 1,0,0,0, 00, 1, 00, 11, 000. Write-back value PC+4 is selected downstream.
  - s_type: 0,1,0,0, 00, 1, 01, 00, 000
  - sb_type: 0,0,0,1, 01, 1, 10, 01, 000. The ALU computes PC+imm; comparison is done in the branch unit.
  - u_type_auipc: 1,0,0,0, 01, 1, 11, 00, 000
  - u_type_lui: 1,0,0,0, 10, 1, 11, 00, 000
  - uj_type: 1,0,0,0, 01, 1, 11, 10, 000
- Reserved codes are never produced.
- X/Z on inputs is not handled; the upstream decoder drives known values.

## Timing
- A combinational decode feeds one register bank. On each rising clk edge every output takes the decode of the flags present at that edge.
- Latency is exactly 1 cycle: a flag change before edge N appears on the outputs after edge N.
- There is no enable or stall input. Pipeline stall and flush are applied by the ID/EX logic downstream.
- rst_n low clears all outputs to 0 (the NOP bundle) immediately, without waiting for clk.
- While rst_n is low, edges are ignored.
- Release is synchronised externally. The first edge with rst_n high loads the decode.
- Reset asserted mid-stream drops the in-flight bundle. No partial state exists.

## Test plan
- Reset: hold rst_n=0 with r_type=1 and toggle clk → all outputs stay 0. Assert rst_n=0 between edges → outputs go to 0 at once.
- Sweep the nine classes one-hot, one per cycle, in order r, lw, addi, jalr, s, sb, auipc, lui, jal. After each edge, check against the decode list; for example lw → write=1, load=1, opB=1, aluop=000, and jal → write=1, opA=01, imm=11, npc=10.
- All flags 0 → after the edge, all outputs are 0. Repeat for several cycles; the outputs stay 0.
- Illegal multi-hot (r_type=1 and s_type=1; also all nine flags high) → NOP bundle, with write=0 and store=0.
- Latency: change the flags just after an edge → outputs keep the previous bundle until the next edge, then update.
- Back-to-back alternating sb_type and u_type_lui → branch toggles 1/0, and opA toggles 01/10 on consecutive cycles.

Source files
------------

// File: rtl/rv32i_control_decoder.sv
// rv32i_control_decoder: registered decode of instruction-class flags into the ID/EX control bundle
module rv32i_control_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r_type,
    input  logic       i_type_lw,
    input  logic       i_type_addi,
    input  logic       i_type_jalr,
    input  logic       s_type,
    input  logic       sb_type,
    input  logic       u_type_auipc,
    input  logic       u_type_lui,
    input  logic       uj_type,
    output logic       write,
    output logic       store,
    output logic       load,
    output logic       branch,
    output logic [1:0] alu_operand_a_selector,
    output logic       alu_operand_b_selector,
    output logic [1:0] immediate_selector,
    output logic [1:0] next_pc_selector,
    output logic [2:0] alu_operations_selector
);
    logic [8:0]  flags;
    logic [13:0] bundle;

    assign flags = {r_type, i_type_lw, i_type_addi, i_type_jalr, s_type,
                    sb_type, u_type_auipc, u_type_lui, uj_type};

    // bundle = {write,store,load,branch,opa,opb,imm,npc,aluop}; anything not one-hot is a NOP
    always_comb begin
        case (flags)
            9'b100000000: bundle = 14'b1000_00_0_00_00_001;
            9'b010000000: bundle = 14'b1010_00_1_00_00_000;
            9'b001000000: bundle = 14'b1000_00_1_00_00_010;
            9'b000100000: bundle = 14'b1000_00_1_00_11_000;
            9'b000010000: bundle = 14'b0100_00_1_01_00_000;
            9'b000001000: bundle = 14'b0001_01_1_10_01_000;
            9'b000000100: bundle = 14'b1000_01_1_11_00_000;
            9'b000000010: bundle = 14'b1000_10_1_11_00_000;
            9'b000000001: bundle = 14'b1000_01_1_11_10_000;
            default:      bundle = 14'b0;
        endcase
    end

    // register the bundle into the ID/EX boundary; reset forces the NOP bundle immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {write, store, load, branch, alu_operand_a_selector, alu_operand_b_selector,
             immediate_selector, next_pc_selector, alu_operations_selector} <= 14'b0;
        else
            {write, store, load, branch, alu_operand_a_selector, alu_operand_b_selector,
             immediate_selector, next_pc_selector, alu_operations_selector} <= bundle;
    end
endmodule

// File: tb/tb_rv32i_control_decoder.sv
// tb_rv32i_control_decoder: directed checks of the registered control decoder
module tb_rv32i_control_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type, u_type_auipc, u_type_lui, uj_type;
    logic write, store, load, branch, opb;
    logic [1:0] opa, imm, npc;
    logic [2:0] aluop;
    int total = 0;
    int bad = 0;

    localparam logic [13:0] NOP   = 14'b0000_00_0_00_00_000;
    localparam logic [13:0] R     = 14'b1000_00_0_00_00_001;
    localparam logic [13:0] LW    = 14'b1010_00_1_00_00_000;
    localparam logic [13:0] ADDI  = 14'b1000_00_1_00_00_010;
    localparam logic [13:0] JALR  = 14'b1000_00_1_00_11_000;
    localparam logic [13:0] S     = 14'b0100_00_1_01_00_000;
    localparam logic [13:0] SB    = 14'b0001_01_1_10_01_000;
    localparam logic [13:0] AUIPC = 14'b1000_01_1_11_00_000;
    localparam logic [13:0] LUI   = 14'b1000_10_1_11_00_000;
    localparam logic [13:0] JAL   = 14'b1000_01_1_11_10_000;

    rv32i_control_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .r_type(r_type), .i_type_lw(i_type_lw), .i_type_addi(i_type_addi),
        .i_type_jalr(i_type_jalr), .s_type(s_type), .sb_type(sb_type),
        .u_type_auipc(u_type_auipc), .u_type_lui(u_type_lui), .uj_type(uj_type),
        .write(write), .store(store), .load(load), .branch(branch),
        .alu_operand_a_selector(opa), .alu_operand_b_selector(opb),
        .immediate_selector(imm), .next_pc_selector(npc),
        .alu_operations_selector(aluop)
    );

    always #5 clk = ~clk;

    task automatic set_flags(input logic [8:0] f);
        {r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type, u_type_auipc, u_type_lui, uj_type} = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        obs = {write, store, load, branch, opa, opb, imm, npc, aluop};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        set_flags(9'b100000000);
        #1;
        check("reset_initial", NOP);
        step(); check("reset_hold_edge1", NOP);
        step(); check("reset_hold_edge2", NOP);
        rst_n = 1'b1;
        step(); check("sweep_r", R);
        set_flags(9'b010000000); step(); check("sweep_lw", LW);
        set_flags(9'b001000000); step(); check("sweep_addi", ADDI);
        set_flags(9'b000100000); step(); check("sweep_jalr", JALR);
        set_flags(9'b000010000); step(); check("sweep_s", S);
        set_flags(9'b000001000); step(); check("sweep_sb", SB);
        set_flags(9'b000000100); step(); check("sweep_auipc", AUIPC);
        set_flags(9'b000000010); step(); check("sweep_lui", LUI);
        set_flags(9'b000000001); step(); check("sweep_jal", JAL);
        #3 rst_n = 1'b0;
        #1 check("async_reset_mid_cycle", NOP);
        step(); check("reset_ignores_edge", NOP);
        rst_n = 1'b1;
        set_flags(9'b000000000);
        step(); check("zero_flags_1", NOP);
        step(); check("zero_flags_2", NOP);
        step(); check("zero_flags_3", NOP);
        set_flags(9'b010000000); step(); check("lw_again", LW);
        set_flags(9'b100010000); step(); check("multi_r_s", NOP);
        set_flags(9'b111111111); step(); check("multi_all", NOP);
        set_flags(9'b000000001); step(); check("latency_jal", JAL);
        set_flags(9'b000010000);
        #2 check("latency_hold", JAL);
        step(); check("latency_update", S);
        set_flags(9'b000001000); step(); check("alt_sb_1", SB);
        set_flags(9'b000000010); step(); check("alt_lui_1", LUI);
        set_flags(9'b000001000); step(); check("alt_sb_2", SB);
        set_flags(9'b000000010); step(); check("alt_lui_2", LUI);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
